// File: rtl/i2c_txn_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_pkg : shared FSM encoding, response codes and rw encoding        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3
   } state_e;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_NACK    = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, first request at or     |
// | above ptr_i, wrapping. rev 1.0                                       |
// +----------------------------------------------------------------------+
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDW-1:0]     ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDW-1:0]     idx_o,
   output logic               any_o
);

   logic [NUM_REQ-1:0] rot;
   logic [IDW:0]       sum;

   always_comb begin
      rot     = NUM_REQ'({req_i, req_i} >> ptr_i);
      sum     = '0;
      any_o   = 1'b0;
      grant_o = '0;
      // Descending scan: the last hit kept is the nearest one to ptr_i.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sum   = {1'b0, ptr_i} + (IDW+1)'(k);
            any_o = 1'b1;
         end
      end
      if (sum >= (IDW+1)'(NUM_REQ)) begin
         sum = sum - (IDW+1)'(NUM_REQ);
      end
      idx_o = sum[IDW-1:0];
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_o[i] = any_o && (idx_o == IDW'(i));
      end
   end

endmodule
`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_txn_arbiter : shares one i2c master between NUM_REQ requesters   |
// | of single-byte transactions, round-robin. rev 1.0                    |
// +----------------------------------------------------------------------+
module i2c_txn_arbiter
   import i2c_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int IDW            = $clog2(NUM_REQ),
   parameter int TW             = $clog2(TIMEOUT_CYCLES) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ-1:0]     req_rw,
   input  logic [8*NUM_REQ-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [7:0]             rsp_rdata,
   output logic [1:0]             rsp_err,
   output logic                   m_start,
   output logic                   m_rw,
   output logic [7:0]             m_wdata,
   input  logic                   m_busy,
   input  logic                   m_done,
   input  logic                   m_nack,
   input  logic [7:0]             m_rdata,
   output logic [IDW-1:0]         grant_id,
   output logic [2:0]             state
);

   state_e              state_q, state_d;
   logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]      grant_q, grant_d;
   logic                m_rw_q, m_rw_d;
   logic [7:0]          m_wdata_q, m_wdata_d;
   logic [7:0]          rdata_q, rdata_d;
   logic [1:0]          err_q, err_d;
   logic [TW-1:0]       timer_q, timer_d;

   logic [NUM_REQ-1:0]  arb_grant;
   logic [IDW-1:0]      arb_idx;
   logic                arb_any;
   logic                accept;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr_arbiter (
      .req_i   (req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx),
      .any_o   (arb_any)
   );

   // rst gates the accept so req_ready stays low while reset is held.
   assign accept = (state_q == ST_IDLE) && arb_any && !m_busy && rst;

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      grant_d   = grant_q;
      m_rw_d    = m_rw_q;
      m_wdata_d = m_wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      timer_d   = timer_q;
      req_ready = '0;
      rsp_valid = '0;
      m_start   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               req_ready = arb_grant;
               grant_d   = arb_idx;
               m_rw_d    = req_rw[arb_idx];
               m_wdata_d = req_wdata[{arb_idx, 3'b000} +: 8];
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            m_start = 1'b1;
            // Timer counts cycles since m_start, so the response lands
            // exactly TIMEOUT_CYCLES after the start pulse on abort.
            timer_d = TW'(1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            timer_d = timer_q + 1'b1;
            if (m_done) begin
               err_d   = m_nack ? ERR_NACK : ERR_OK;
               rdata_d = (m_rw_q == READ && !m_nack) ? m_rdata : 8'h00;
               state_d = ST_RESP;
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               err_d   = ERR_TIMEOUT;
               rdata_d = 8'h00;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            for (int i = 0; i < NUM_REQ; i++) begin
               rsp_valid[i] = (grant_q == IDW'(i));
            end
            rr_ptr_d = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         m_rw_q    <= WRITE;
         m_wdata_q <= 8'h00;
         rdata_q   <= 8'h00;
         err_q     <= ERR_OK;
         timer_q   <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         grant_q   <= grant_d;
         m_rw_q    <= m_rw_d;
         m_wdata_q <= m_wdata_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         timer_q   <= timer_d;
      end
   end

   assign m_rw      = m_rw_q;
   assign m_wdata   = m_wdata_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign grant_id  = grant_q;
   assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_i2c_txn_arbiter : directed bench with a cycle-stamped model       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_i2c_txn_arbiter;

   localparam int N = 4;
   localparam int T = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   req_rw = '0;
   logic [8*N-1:0] req_wdata = '0;
   logic [N-1:0]   rsp_valid;
   logic [7:0]     rsp_rdata;
   logic [1:0]     rsp_err;
   logic           m_start;
   logic           m_rw;
   logic [7:0]     m_wdata;
   logic           m_busy = 1'b0;
   logic           m_done = 1'b0;
   logic           m_nack = 1'b0;
   logic [7:0]     m_rdata = '0;
   logic [1:0]     grant_id;
   logic [2:0]     dbg_state;

   always #5 clk = ~clk;

   i2c_txn_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (T),
      .IDW            (2),
      .TW             (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rw    (req_rw),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .m_start   (m_start),
      .m_rw      (m_rw),
      .m_wdata   (m_wdata),
      .m_busy    (m_busy),
      .m_done    (m_done),
      .m_nack    (m_nack),
      .m_rdata   (m_rdata),
      .grant_id  (grant_id),
      .state     (dbg_state)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: a transaction is in flight from accept until its response cycle;
   // events are tracked as absolute cycle numbers.
   int           cyc = 0;
   bit           mf = 1'b0;
   int           mown = 0, mgrant = 0, mptr = 0, mstart = 0, mresp = -1;
   logic         mrw = 1'b0;
   logic [7:0]   mwd = '0, mrd = '0;
   logic [1:0]   merr = '0;
   logic [N-1:0] acc_log[$];

   always @(negedge clk) begin
      logic [N-1:0] er, ev;
      logic [2:0]   es;
      logic         est;
      int           w;
      cyc++;
      er = '0; ev = '0; es = 3'd0; est = 1'b0; w = -1;
      if (!rst) begin
         mf = 1'b0; mptr = 0; mgrant = 0; mrw = 1'b0; mwd = '0; mrd = '0; merr = '0;
      end else begin
         if (!mf && !m_busy) begin
            for (int k = 0; k < N; k++) begin
               if (w < 0 && req_valid[(mptr + k) % N]) w = (mptr + k) % N;
            end
         end
         if (w >= 0) er[w] = 1'b1;
         if (mf && cyc == mresp) ev[mown] = 1'b1;
         est = mf && (cyc == mstart);
         es  = !mf ? 3'd0 : (cyc == mstart) ? 3'd1 : (cyc == mresp) ? 3'd3 : 3'd2;
      end
      check("req_ready", 32'(req_ready), 32'(er));
      check("rsp_valid", 32'(rsp_valid), 32'(ev));
      check("m_start",   32'(m_start),   32'(est));
      check("m_rw",      32'(m_rw),      32'(mrw));
      check("m_wdata",   32'(m_wdata),   32'(mwd));
      check("rsp_rdata", 32'(rsp_rdata), 32'(mrd));
      check("rsp_err",   32'(rsp_err),   32'(merr));
      check("grant_id",  32'(grant_id),  32'(mgrant));
      check("state",     32'(dbg_state), 32'(es));
      if (req_ready != '0) acc_log.push_back(req_ready);
      if (rst) begin
         if (w >= 0) begin
            mf = 1'b1; mown = w; mgrant = w; mrw = req_rw[w];
            mwd = req_wdata[8*w +: 8]; mstart = cyc + 1; mresp = -1;
         end else if (mf && cyc == mresp) begin
            mf = 1'b0; mptr = (mown + 1) % N;
         end else if (mf && mresp < 0 && cyc > mstart) begin
            if (m_done) begin
               merr = m_nack ? 2'b01 : 2'b00;
               mrd = (mrw && !m_nack) ? m_rdata : 8'h00;
               mresp = cyc + 1;
            end else if (cyc - mstart == T - 1) begin
               merr = 2'b10; mrd = 8'h00; mresp = cyc + 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(output int n);
      n = 0;
      while (!m_start && n < 200) begin tick(); n++; end
      if (!m_start) check("m_start_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (rsp_valid == '0 && n < 200) begin tick(); n++; end
      if (rsp_valid == '0) check("rsp_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_done(input int d, input logic nack, input logic [7:0] rd);
      repeat (d) tick();
      m_done = 1'b1; m_nack = nack; m_rdata = rd;
      tick();
      m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
   endtask

   initial begin
      int n;
      logic [N-1:0] rsp_seq[5];
      logic [N-1:0] exp_seq[5];
      exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
      exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;

      #1 rst = 1'b0;
      req_valid = 4'b1111;
      repeat (3) tick();
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_state", 32'(dbg_state), 32'd0);

      // Round robin with all four requesting continuously
      acc_log.delete();
      rst = 1'b1;
      #1 check("rr_first_ready", 32'(req_ready), 32'h1);
      for (int i = 0; i < 5; i++) begin
         wait_start(n);
         pulse_done(5, 1'b0, 8'h00);
         wait_rsp(n);
         rsp_seq[i] = rsp_valid;
      end
      req_valid = '0;
      check("rr_accept_count", 32'(acc_log.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < acc_log.size()) check("rr_accept_order", 32'(acc_log[i]), 32'(exp_seq[i]));
         check("rr_rsp_order", 32'(rsp_seq[i]), 32'(exp_seq[i]));
      end
      tick();

      // Single write from requester 0; inputs change after accept
      req_rw = 4'b0000; req_wdata[7:0] = 8'hA5; req_valid = 4'b0001;
      #1 check("wr_ready", 32'(req_ready), 32'h1);
      wait_start(n);
      check("wr_start_latency", 32'(n), 32'd1);
      req_valid = '0; req_rw = 4'b1111; req_wdata = '0;
      check("wr_m_rw", 32'(m_rw), 32'd0);
      check("wr_m_wdata", 32'(m_wdata), 32'hA5);
      pulse_done(3, 1'b0, 8'hFF);
      wait_rsp(n);
      check("wr_rsp_latency", 32'(n), 32'd0);
      check("wr_rsp_valid", 32'(rsp_valid), 32'h1);
      check("wr_rsp_err", 32'(rsp_err), 32'd0);
      check("wr_rsp_rdata", 32'(rsp_rdata), 32'h00);
      tick();

      // Read from requester 2
      req_rw = 4'b0100; req_valid = 4'b0100;
      wait_start(n);
      req_valid = '0;
      check("rd_grant_id", 32'(grant_id), 32'd2);
      check("rd_m_rw", 32'(m_rw), 32'd1);
      pulse_done(4, 1'b0, 8'h3C);
      wait_rsp(n);
      check("rd_rsp_valid", 32'(rsp_valid), 32'h4);
      check("rd_rsp_rdata", 32'(rsp_rdata), 32'h3C);
      check("rd_rsp_err", 32'(rsp_err), 32'd0);
      tick();
      check("rd_rdata_hold", 32'(rsp_rdata), 32'h3C);

      // Nack on a read from requester 1
      req_rw = 4'b0010; req_valid = 4'b0010;
      wait_start(n);
      req_valid = '0;
      pulse_done(2, 1'b1, 8'h77);
      wait_rsp(n);
      check("nack_rsp_valid", 32'(rsp_valid), 32'h2);
      check("nack_rsp_err", 32'(rsp_err), 32'd1);
      check("nack_rsp_rdata", 32'(rsp_rdata), 32'h00);
      tick();

      // Timeout on requester 3
      req_rw = 4'b0000; req_wdata[31:24] = 8'h5A; req_valid = 4'b1000;
      wait_start(n);
      req_valid = '0;
      check("to_m_wdata", 32'(m_wdata), 32'h5A);
      wait_rsp(n);
      check("to_rsp_delay", 32'(n), 32'd16);
      check("to_rsp_valid", 32'(rsp_valid), 32'h8);
      check("to_rsp_err", 32'(rsp_err), 32'd2);
      tick();

      // m_done on the timeout cycle wins
      req_valid = 4'b0001;
      wait_start(n);
      req_valid = '0;
      pulse_done(15, 1'b0, 8'h00);
      wait_rsp(n);
      check("to_done_delay", 32'(n), 32'd0);
      check("to_done_err", 32'(rsp_err), 32'd0);
      tick();

      // Busy gating, with a stray m_done while idle
      m_busy = 1'b1; req_valid = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         #1 check("busy_no_ready", 32'(req_ready), 32'd0);
         if (i == 1) m_done = 1'b1;
         tick();
         m_done = 1'b0;
      end
      check("busy_no_rsp", 32'(rsp_valid), 32'd0);
      m_busy = 1'b0;
      #1 check("busy_release_ready", 32'(req_ready), 32'h2);
      wait_start(n);
      req_valid = '0;
      pulse_done(2, 1'b0, 8'h00);
      wait_rsp(n);
      check("busy_rsp_valid", 32'(rsp_valid), 32'h2);
      tick();

      // Reset mid-WAIT; rr_ptr must come back at 0
      req_valid = 4'b0001;
      wait_start(n);
      repeat (3) tick();
      #2 rst = 1'b0;
      #1;
      check("rst_m_start", 32'(m_start), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      check("rst_m_wdata", 32'(m_wdata), 32'd0);
      req_valid = 4'b0101;
      repeat (2) tick();
      check("rst_hold_rsp", 32'(rsp_valid), 32'd0);
      rst = 1'b1;
      #1 check("rst_ptr_zero_ready", 32'(req_ready), 32'h1);
      wait_start(n);
      req_valid = '0;
      check("rst_grant_id", 32'(grant_id), 32'd0);
      pulse_done(2, 1'b0, 8'h00);
      wait_rsp(n);
      check("rst_rsp_valid_after", 32'(rsp_valid), 32'h1);
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
